mar_req_queue: RTL and testbench

- Parametrised successor to the single-entry memory address register.
- Buffers up to DEPTH memory requests; each request is an address, a size (byte/word) and a read/write flag.
- Issues the requests in order to a fixed-latency memory and holds the active request on its outputs for the whole access.
- Rejects word accesses to odd addresses.
- Sits between the datapath address mux and the memory interface of the LC-3b core.

---
 rtl/mar_req_queue.sv | 155 +++++++++++++++
 tb/tb_mar_req_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mar_req_queue.sv
// Request queue in front of the memory address register: buffers up to DEPTH
// requests and issues them in order to a fixed-latency memory.
module mar_req_queue #(
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 4,
    parameter int MEM_LAT = 5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       ld_mar,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic                       in_size,
    input  logic                       in_write,
    input  logic                       flush,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_size,
    output logic                       mem_write,
    output logic                       mem_en,
    output logic                       mem_r,
    output logic                       unaligned,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;

    logic [ADDR_W-1:0]   q_addr  [DEPTH];
    logic                q_size  [DEPTH];
    logic                q_write [DEPTH];

    logic                misaligned;
    logic                is_full;
    logic                push;
    logic                pop;

    assign misaligned = in_size & in_addr[0];
    // Fullness is judged on the pre-edge count, so a same-edge pop never makes room.
    assign is_full    = (count_q == CNT_W'(DEPTH));
    assign push       = ld_mar & ~flush & ~misaligned & ~is_full;

    assign full  = is_full;
    assign count = count_q;

    // FSM next state, pop decision and access outputs
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        pop     = 1'b0;
        mem_en  = 1'b0;
        mem_r   = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = BUSY;
                    lat_d   = LAT_LOAD;
                end
            end
            BUSY: begin
                mem_en = 1'b1;
                if (lat_q == '0) begin
                    mem_r = 1'b1;
                    if (count_q != '0) begin
                        pop   = 1'b1;
                        lat_d = LAT_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                lat_d   = '0;
            end
        endcase
        if (flush) begin
            pop     = 1'b0;
            state_d = IDLE;
            lat_d   = '0;
        end
    end

    // Control state: FSM, latency counter, queue pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Queue storage carries no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr_q]  <= in_addr;
            q_size[wr_ptr_q]  <= in_size;
            q_write[wr_ptr_q] <= in_write;
        end
    end

    // Issued-request registers hold their value between accesses, like the MAR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr  <= '0;
            mem_size  <= 1'b0;
            mem_write <= 1'b0;
        end else if (pop) begin
            mem_addr  <= q_addr[rd_ptr_q];
            mem_size  <= q_size[rd_ptr_q];
            mem_write <= q_write[rd_ptr_q];
        end
    end

    // Rejection pulses last one cycle; a flush suppresses both.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            unaligned <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            unaligned <= ld_mar & ~flush & misaligned;
            overflow  <= ld_mar & ~flush & ~misaligned & is_full;
        end
    end

endmodule

// File: tb/tb_mar_req_queue.sv
// Directed bench for mar_req_queue with DEPTH=4, MEM_LAT=3, ADDR_W=16.
module tb_mar_req_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ld_mar;
    logic [15:0] in_addr;
    logic        in_size;
    logic        in_write;
    logic        flush;
    logic        full;
    logic [2:0]  count;
    logic [15:0] mem_addr;
    logic        mem_size;
    logic        mem_write;
    logic        mem_en;
    logic        mem_r;
    logic        unaligned;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Back-to-back expectations, one entry per edge starting at the first load.
    int b2b_en   [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int b2b_r    [11] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
    int b2b_addr [11] = '{'h3000, 'h3000, 'h3000, 'h3000, 'h3002, 'h3002,
                          'h3002, 'h3005, 'h3005, 'h3005, 'h3005};
    int b2b_cnt  [11] = '{1, 1, 2, 2, 1, 1, 1, 0, 0, 0, 0};

    mar_req_queue #(.ADDR_W(16), .DEPTH(4), .MEM_LAT(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ld_mar    (ld_mar),
        .in_addr   (in_addr),
        .in_size   (in_size),
        .in_write  (in_write),
        .flush     (flush),
        .full      (full),
        .count     (count),
        .mem_addr  (mem_addr),
        .mem_size  (mem_size),
        .mem_write (mem_write),
        .mem_en    (mem_en),
        .mem_r     (mem_r),
        .unaligned (unaligned),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] a, input logic s, input logic w);
        ld_mar   = 1'b1;
        in_addr  = a;
        in_size  = s;
        in_write = w;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        ld_mar = 1'b0; in_addr = '0; in_size = 1'b0; in_write = 1'b0; flush = 1'b0;
        step(); step();
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_r", 32'(mem_r), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_flags", 32'({unaligned, overflow, mem_size, mem_write}), 0);
        reset_n = 1'b1;
        step();

        // Single read
        load(16'h3000, 1'b1, 1'b0);
        step();                       // edge 1
        ld_mar = 1'b0;
        chk("sr_cnt1", 32'(count), 1);
        chk("sr_en1", 32'(mem_en), 0);
        step();                       // edge 2
        chk("sr_en2", 32'(mem_en), 1);
        chk("sr_addr2", 32'(mem_addr), 32'h3000);
        chk("sr_r2", 32'(mem_r), 0);
        chk("sr_size2", 32'(mem_size), 1);
        step();                       // edge 3
        chk("sr_r3", 32'(mem_r), 0);
        step();                       // edge 4
        chk("sr_en4", 32'(mem_en), 1);
        chk("sr_r4", 32'(mem_r), 1);
        step();                       // edge 5
        chk("sr_en5", 32'(mem_en), 0);
        chk("sr_r5", 32'(mem_r), 0);
        chk("sr_hold", 32'(mem_addr), 32'h3000);
        step();

        // Back-to-back: three loads on consecutive edges
        for (int i = 0; i < 11; i++) begin
            if (i == 0)      load(16'h3000, 1'b1, 1'b0);
            else if (i == 1) load(16'h3002, 1'b1, 1'b1);
            else if (i == 2) load(16'h3005, 1'b0, 1'b0);
            else             ld_mar = 1'b0;
            step();
            chk($sformatf("b2b_en%0d", i), 32'(mem_en), 32'(b2b_en[i]));
            chk($sformatf("b2b_r%0d", i), 32'(mem_r), 32'(b2b_r[i]));
            chk($sformatf("b2b_addr%0d", i), 32'(mem_addr), 32'(b2b_addr[i]));
            chk($sformatf("b2b_cnt%0d", i), 32'(count), 32'(b2b_cnt[i]));
            if (i == 4) chk("b2b_write", 32'(mem_write), 1);
            if (i == 7) chk("b2b_size", 32'(mem_size), 0);
        end
        step();

        // Unaligned word rejected, same address as byte accepted
        load(16'h3001, 1'b1, 1'b0);
        step();
        ld_mar = 1'b0;
        chk("ua_pulse", 32'(unaligned), 1);
        chk("ua_cnt", 32'(count), 0);
        chk("ua_ovf", 32'(overflow), 0);
        step();
        chk("ua_pulse_end", 32'(unaligned), 0);
        chk("ua_no_en", 32'(mem_en), 0);
        step();
        chk("ua_no_en2", 32'(mem_en), 0);
        load(16'h3001, 1'b0, 1'b0);
        step();
        ld_mar = 1'b0;
        chk("ub_cnt", 32'(count), 1);
        chk("ub_no_pulse", 32'(unaligned), 0);
        step();
        chk("ub_en", 32'(mem_en), 1);
        chk("ub_addr", 32'(mem_addr), 32'h3001);
        step(); step(); step();
        chk("ub_idle", 32'(mem_en), 0);

        // Overflow: one issued, four queued while busy, fifth dropped
        for (int i = 0; i < 7; i++) begin
            load(16'(16'h4000 + 2 * i), 1'b1, 1'b0);
            step();
            if (i == 5) begin
                chk("of_full", 32'(full), 1);
                chk("of_cnt4", 32'(count), 4);
                chk("of_no_pulse", 32'(overflow), 0);
            end
        end
        ld_mar = 1'b0;
        chk("of_pulse", 32'(overflow), 1);
        chk("of_cnt_hold", 32'(count), 4);
        step();                       // f8
        chk("of_pulse_end", 32'(overflow), 0);
        chk("of_addr_f8", 32'(mem_addr), 32'h4004);
        chk("of_cnt_f8", 32'(count), 3);
        step(); step(); step();       // f11
        chk("of_addr_f11", 32'(mem_addr), 32'h4006);
        step(); step(); step();       // f14
        chk("of_addr_f14", 32'(mem_addr), 32'h4008);
        step(); step(); step();       // f17
        chk("of_addr_f17", 32'(mem_addr), 32'h400A);
        step(); step(); step();       // f20
        chk("of_end_en", 32'(mem_en), 0);
        chk("of_end_addr", 32'(mem_addr), 32'h400A);
        step();

        // Flush in the second cycle of an access with two entries queued
        load(16'h5000, 1'b1, 1'b1);
        step();                       // g1
        load(16'h5002, 1'b1, 1'b0);
        step();                       // g2
        load(16'h5004, 1'b1, 1'b0);
        step();                       // g3
        chk("fl_pre_cnt", 32'(count), 2);
        chk("fl_pre_en", 32'(mem_en), 1);
        load(16'h5001, 1'b1, 1'b0);   // concurrent misaligned load must be ignored
        flush = 1'b1;
        step();                       // g4
        flush = 1'b0;
        ld_mar = 1'b0;
        chk("fl_en", 32'(mem_en), 0);
        chk("fl_r", 32'(mem_r), 0);
        chk("fl_cnt", 32'(count), 0);
        chk("fl_addr", 32'(mem_addr), 32'h5000);
        chk("fl_no_ua", 32'(unaligned), 0);
        step();
        chk("fl_en_after", 32'(mem_en), 0);
        chk("fl_r_after", 32'(mem_r), 0);
        step();

        // Asynchronous reset mid-access
        load(16'h6000, 1'b1, 1'b0);
        step();                       // h1
        load(16'h6002, 1'b1, 1'b0);
        step();                       // h2
        ld_mar = 1'b0;
        step();                       // h3
        #1;
        chk("ar_pre_cnt", 32'(count), 1);
        reset_n = 1'b0;
        #1;
        chk("ar_en", 32'(mem_en), 0);
        chk("ar_r", 32'(mem_r), 0);
        chk("ar_cnt", 32'(count), 0);
        chk("ar_addr", 32'(mem_addr), 0);
        #1;
        reset_n = 1'b1;
        step();
        load(16'h7000, 1'b1, 1'b0);
        step();                       // k1
        ld_mar = 1'b0;
        chk("ar_new_cnt", 32'(count), 1);
        step();                       // k2
        chk("ar_new_en", 32'(mem_en), 1);
        chk("ar_new_addr", 32'(mem_addr), 32'h7000);
        step(); step();               // k4
        chk("ar_new_r", 32'(mem_r), 1);
        step();                       // k5
        chk("ar_new_idle", 32'(mem_en), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
